// File: rtl/csr_hpm_unit.sv
// rtl/csr_hpm_unit.sv - machine/user performance counter CSR bank with event selectors and overflow IRQ
module csr_hpm_unit #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 64,
  parameter int NUM_EVT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_valid_i,
  input  logic [1:0]         csr_op_i,
  input  logic [11:0]        csr_addr_i,
  input  logic [31:0]        csr_wdata_i,
  input  logic               csr_wr_suppress_i,
  input  logic [1:0]         priv_i,
  input  logic               retire_i,
  input  logic [NUM_EVT-1:0] event_i,
  output logic               csr_hit_o,
  output logic               csr_fault_o,
  output logic               csr_rvalid_o,
  output logic [31:0]        csr_rdata_o,
  output logic               ovf_irq_o,
  output logic [NUM_CNT-1:0] ovf_status_o
);

  localparam logic [63:0] CNT_BITS = (64'd1 << (3 + NUM_CNT)) - 64'd1;
  localparam logic [31:0] EN_MASK  = CNT_BITS[31:0];
  localparam logic [31:0] INH_MASK = CNT_BITS[31:0] & 32'hFFFF_FFFD;
  localparam logic [5:0]  HPM_END  = 6'(3 + NUM_CNT);

  logic [CNT_W-1:0]   mcycle_q, minstret_q;
  logic [CNT_W-1:0]   hpm_q [NUM_CNT];
  logic [7:0]         sel_q [NUM_CNT];
  logic [NUM_CNT-1:0] of_q;
  logic [31:0]        inhibit_q, counteren_q;

  function automatic logic [63:0] widen(input logic [CNT_W-1:0] c);
    logic [63:0] w;
    w = '0;
    w[CNT_W-1:0] = c;
    return w;
  endfunction

  // Replace one 32-bit half of a counter, leaving the other half untouched.
  function automatic logic [CNT_W-1:0] merge(input logic [CNT_W-1:0] c, input logic hi,
                                             input logic [31:0] v);
    logic [63:0] w;
    w = widen(c);
    if (hi) w[63:32] = v;
    else    w[31:0]  = v;
    return w[CNT_W-1:0];
  endfunction

  logic [4:0] idx;
  logic       hi_half, idx_hpm, is_cnt, is_shadow, is_evt, is_inh, is_en;
  logic       wr_req, access, wr_en;

  assign idx       = csr_addr_i[4:0];
  assign hi_half   = csr_addr_i[7];
  assign idx_hpm   = ({1'b0, idx} >= 6'd3) && ({1'b0, idx} < HPM_END);
  assign is_cnt    = (csr_addr_i[11:8] == 4'hB || csr_addr_i[11:8] == 4'hC) &&
                     (csr_addr_i[6:5] == 2'b00) &&
                     (idx == 5'd0 || idx == 5'd2 || idx_hpm);
  assign is_shadow = is_cnt && (csr_addr_i[11:8] == 4'hC);
  assign is_evt    = (csr_addr_i[11:5] == 7'h19) && idx_hpm;
  assign is_inh    = (csr_addr_i == 12'h320);
  assign is_en     = (csr_addr_i == 12'h306);
  assign csr_hit_o = is_cnt || is_evt || is_inh || is_en;

  // RS/RC with a zero operand is a pure read and may target read-only CSRs.
  assign wr_req = (csr_op_i == 2'b01) || (csr_op_i[1] && !csr_wr_suppress_i);

  assign csr_fault_o = csr_valid_i && csr_hit_o &&
                       ((priv_i < csr_addr_i[9:8]) ||
                        ((csr_addr_i[11:10] == 2'b11) && wr_req) ||
                        (is_shadow && (priv_i != 2'b11) && !counteren_q[idx]));

  assign access = csr_valid_i && csr_hit_o && !csr_fault_o;
  assign wr_en  = access && wr_req;

  logic [63:0] cnt64;
  logic [31:0] old_val, new_val;

  always_comb begin
    cnt64   = '0;
    old_val = '0;
    if (idx == 5'd0)      cnt64 = widen(mcycle_q);
    else if (idx == 5'd2) cnt64 = widen(minstret_q);
    for (int i = 0; i < NUM_CNT; i++)
      if (idx == 5'(i + 3)) cnt64 = widen(hpm_q[i]);
    if (is_cnt) begin
      old_val = hi_half ? cnt64[63:32] : cnt64[31:0];
    end else if (is_evt) begin
      for (int i = 0; i < NUM_CNT; i++)
        if (idx == 5'(i + 3)) old_val = {of_q[i], 23'd0, sel_q[i]};
    end else if (is_inh) begin
      old_val = inhibit_q;
    end else if (is_en) begin
      old_val = counteren_q;
    end
  end

  always_comb begin
    new_val = csr_wdata_i;
    case (csr_op_i)
      2'b10:   new_val = old_val | csr_wdata_i;
      2'b11:   new_val = old_val & ~csr_wdata_i;
      default: new_val = csr_wdata_i;
    endcase
  end

  logic               wr_cyc, wr_ret, wr_inh, wr_cen;
  logic [NUM_CNT-1:0] wr_hpm, wr_evt, inc_hpm, wrap;

  assign wr_cyc = wr_en && is_cnt && (idx == 5'd0);
  assign wr_ret = wr_en && is_cnt && (idx == 5'd2);
  assign wr_inh = wr_en && is_inh;
  assign wr_cen = wr_en && is_en;

  // A selector of 0 or beyond NUM_EVT matches no event line and never counts.
  always_comb begin
    wr_hpm  = '0;
    wr_evt  = '0;
    inc_hpm = '0;
    wrap    = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      wr_hpm[i] = wr_en && is_cnt && (idx == 5'(i + 3));
      wr_evt[i] = wr_en && is_evt && (idx == 5'(i + 3));
      for (int j = 0; j < NUM_EVT; j++)
        if (sel_q[i] == 8'(j + 1) && event_i[j]) inc_hpm[i] = !inhibit_q[3 + i];
      wrap[i] = inc_hpm[i] && !wr_hpm[i] && (&hpm_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_q    <= '0;
      minstret_q  <= '0;
      of_q        <= '0;
      inhibit_q   <= '0;
      counteren_q <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        hpm_q[i] <= '0;
        sel_q[i] <= '0;
      end
    end else begin
      if (wr_cyc)             mcycle_q <= merge(mcycle_q, hi_half, new_val);
      else if (!inhibit_q[0]) mcycle_q <= mcycle_q + 1'b1;

      if (wr_ret)                        minstret_q <= merge(minstret_q, hi_half, new_val);
      else if (retire_i && !inhibit_q[2]) minstret_q <= minstret_q + 1'b1;

      for (int i = 0; i < NUM_CNT; i++) begin
        if (wr_hpm[i])       hpm_q[i] <= merge(hpm_q[i], hi_half, new_val);
        else if (inc_hpm[i]) hpm_q[i] <= hpm_q[i] + 1'b1;
        if (wr_evt[i])       sel_q[i] <= new_val[7:0];
        if (wrap[i])         of_q[i]  <= 1'b1;
        else if (wr_evt[i])  of_q[i]  <= new_val[31];
      end

      if (wr_inh) inhibit_q   <= new_val & INH_MASK;
      if (wr_cen) counteren_q <= new_val & EN_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr_rvalid_o <= 1'b0;
      csr_rdata_o  <= '0;
      ovf_irq_o    <= 1'b0;
    end else begin
      csr_rvalid_o <= access;
      if (access) csr_rdata_o <= old_val;
      ovf_irq_o <= |of_q;
    end
  end

  assign ovf_status_o = of_q;

endmodule

// File: tb/tb_csr_hpm_unit.sv
// tb/tb_csr_hpm_unit.sv - directed self-checking bench for csr_hpm_unit
module tb_csr_hpm_unit;
  localparam int NUM_CNT = 4;
  localparam int CNT_W   = 64;
  localparam int NUM_EVT = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               csr_valid;
  logic [1:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [31:0]        csr_wdata;
  logic               csr_wr_suppress;
  logic [1:0]         priv;
  logic               retire;
  logic [NUM_EVT-1:0] event_in;
  logic               csr_hit, csr_fault, csr_rvalid, ovf_irq;
  logic [31:0]        csr_rdata;
  logic [NUM_CNT-1:0] ovf_status;

  int checks = 0;
  int errors = 0;

  logic        r_f, r_h, r_rv;
  logic [31:0] r_rd;

  csr_hpm_unit #(.NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .NUM_EVT(NUM_EVT)) dut (
    .clk(clk), .rst_n(rst_n), .csr_valid_i(csr_valid), .csr_op_i(csr_op),
    .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata), .csr_wr_suppress_i(csr_wr_suppress),
    .priv_i(priv), .retire_i(retire), .event_i(event_in), .csr_hit_o(csr_hit),
    .csr_fault_o(csr_fault), .csr_rvalid_o(csr_rvalid), .csr_rdata_o(csr_rdata),
    .ovf_irq_o(ovf_irq), .ovf_status_o(ovf_status)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One-cycle CSR access; hit/fault sampled mid-request, rvalid/rdata just after the access edge.
  task automatic csr_access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                            input logic sup, input logic [NUM_EVT-1:0] evt);
    @(negedge clk);
    csr_valid = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    csr_wr_suppress = sup; event_in = evt;
    #1 r_f = csr_fault; r_h = csr_hit;
    @(posedge clk);
    #1 r_rv = csr_rvalid; r_rd = csr_rdata;
    csr_valid = 1'b0; csr_op = 2'b00; csr_wr_suppress = 1'b0; event_in = '0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] wd);
    csr_access(2'b01, addr, wd, 1'b0, '0);
  endtask

  task automatic rd(input logic [11:0] addr);
    csr_access(2'b00, addr, 32'd0, 1'b0, '0);
  endtask

  task automatic pulse(input logic [NUM_EVT-1:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); event_in = m;
      @(posedge clk); #1 event_in = '0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; csr_valid = 1'b0; csr_op = 2'b00; csr_addr = 12'h000; csr_wdata = '0;
    csr_wr_suppress = 1'b0; priv = 2'b11; retire = 1'b0; event_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", csr_rvalid); end
    checks++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", csr_rdata); end
    checks++; if (ovf_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", ovf_irq); end
    checks++; if (ovf_status !== 4'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", ovf_status); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mcycle;
    repeat (10) @(posedge clk);
    rd(12'hB00);
    checks++; if (r_rd !== 32'd10) begin errors++; $display("FAIL mcycle_10: got %0d expected 10", r_rd); end
    checks++; if (r_rv !== 1'b1 || r_h !== 1'b1 || r_f !== 1'b0) begin errors++; $display("FAIL mcycle_rvalid: got rv=%b hit=%b fault=%b expected 1 1 0", r_rv, r_h, r_f); end
    @(posedge clk); #1;
    checks++; if (csr_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b expected 0", csr_rvalid); end
    rd(12'hB80);
    checks++; if (r_rd !== 32'd0) begin errors++; $display("FAIL mcycleh: got %h expected 0", r_rd); end
  endtask

  task automatic test_event_count;
    wr(12'h323, 32'd2);
    pulse(8'h02, 5);
    rd(12'hB03);
    checks++; if (r_rd !== 32'd5) begin errors++; $display("FAIL evt_sel2: got %0d expected 5", r_rd); end
    pulse(8'h01, 3);
    rd(12'hB03);
    checks++; if (r_rd !== 32'd5) begin errors++; $display("FAIL evt_other: got %0d expected 5", r_rd); end
    wr(12'h323, 32'd9);
    pulse(8'hFF, 2);
    rd(12'hB03);
    checks++; if (r_rd !== 32'd5) begin errors++; $display("FAIL evt_sel_oob: got %0d expected 5", r_rd); end
    wr(12'h323, 32'd0);
    pulse(8'hFF, 2);
    rd(12'hB03);
    checks++; if (r_rd !== 32'd5) begin errors++; $display("FAIL evt_sel0: got %0d expected 5", r_rd); end
  endtask

  task automatic test_overflow;
    wr(12'h323, 32'd2);
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    pulse(8'h02, 1);
    checks++; if (ovf_status !== 4'b0001) begin errors++; $display("FAIL ovf_status_set: got %b expected 0001", ovf_status); end
    checks++; if (ovf_irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_early: got %b expected 0", ovf_irq); end
    @(posedge clk); #1;
    checks++; if (ovf_irq !== 1'b1) begin errors++; $display("FAIL ovf_irq_rise: got %b expected 1", ovf_irq); end
    rd(12'hB03);
    checks++; if (r_rd !== 32'd0) begin errors++; $display("FAIL wrap_lo: got %h expected 0", r_rd); end
    rd(12'hB83);
    checks++; if (r_rd !== 32'd0) begin errors++; $display("FAIL wrap_hi: got %h expected 0", r_rd); end
    rd(12'h323);
    checks++; if (r_rd !== 32'h8000_0002) begin errors++; $display("FAIL evt_of_read: got %h expected 80000002", r_rd); end
    wr(12'h323, 32'd2);
    checks++; if (ovf_status !== 4'b0000 || ovf_irq !== 1'b1) begin errors++; $display("FAIL of_clear: got status=%b irq=%b expected 0000 1", ovf_status, ovf_irq); end
    @(posedge clk); #1;
    checks++; if (ovf_irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b expected 0", ovf_irq); end
  endtask

  task automatic test_user_access;
    pulse(8'h02, 3);
    priv = 2'b00;
    rd(12'hC03);
    checks++; if (r_f !== 1'b1 || r_rv !== 1'b0) begin errors++; $display("FAIL u_c03_denied: got fault=%b rv=%b expected 1 0", r_f, r_rv); end
    rd(12'hC00);
    checks++; if (r_f !== 1'b1) begin errors++; $display("FAIL u_c00_denied: got %b expected 1", r_f); end
    rd(12'hB00);
    checks++; if (r_f !== 1'b1 || r_rv !== 1'b0) begin errors++; $display("FAIL u_b00_priv: got fault=%b rv=%b expected 1 0", r_f, r_rv); end
    priv = 2'b11;
    wr(12'h306, 32'h8);
    priv = 2'b00;
    rd(12'hC03);
    checks++; if (r_f !== 1'b0 || r_rv !== 1'b1 || r_rd !== 32'd3) begin errors++; $display("FAIL u_c03_ok: got fault=%b rv=%b data=%0d expected 0 1 3", r_f, r_rv, r_rd); end
    priv = 2'b11;
  endtask

  task automatic test_readonly;
    wr(12'h320, 32'h1);
    wr(12'hB00, 32'h1234);
    csr_access(2'b01, 12'hC00, 32'd0, 1'b0, '0);
    checks++; if (r_f !== 1'b1 || r_rv !== 1'b0) begin errors++; $display("FAIL ro_rw_fault: got fault=%b rv=%b expected 1 0", r_f, r_rv); end
    csr_access(2'b10, 12'hC00, 32'd0, 1'b1, '0);
    checks++; if (r_f !== 1'b0 || r_rv !== 1'b1 || r_rd !== 32'h1234) begin errors++; $display("FAIL ro_rs_suppress: got fault=%b rv=%b data=%h expected 0 1 1234", r_f, r_rv, r_rd); end
    csr_access(2'b10, 12'hC00, 32'd0, 1'b0, '0);
    checks++; if (r_f !== 1'b1) begin errors++; $display("FAIL ro_rs_nosuppress: got %b expected 1", r_f); end
    csr_access(2'b11, 12'hB00, 32'h4, 1'b0, '0);
    checks++; if (r_rd !== 32'h1234) begin errors++; $display("FAIL rc_old: got %h expected 1234", r_rd); end
    rd(12'hB00);
    checks++; if (r_rd !== 32'h1230) begin errors++; $display("FAIL rc_new: got %h expected 1230", r_rd); end
  endtask

  task automatic test_write_vs_event;
    csr_access(2'b01, 12'hB03, 32'h100, 1'b0, 8'h02);
    rd(12'hB03);
    checks++; if (r_rd !== 32'h100) begin errors++; $display("FAIL write_wins: got %h expected 100", r_rd); end
    wr(12'h320, 32'h9);
    pulse(8'h02, 5);
    rd(12'hB03);
    checks++; if (r_rd !== 32'h100) begin errors++; $display("FAIL inhibit_hold: got %h expected 100", r_rd); end
    wr(12'hB83, 32'h5);
    rd(12'hB03);
    checks++; if (r_rd !== 32'h100) begin errors++; $display("FAIL hi_write_lo_kept: got %h expected 100", r_rd); end
    rd(12'hB83);
    checks++; if (r_rd !== 32'h5) begin errors++; $display("FAIL hi_write: got %h expected 5", r_rd); end
  endtask

  task automatic test_minstret;
    @(negedge clk); retire = 1'b1;
    repeat (4) @(posedge clk);
    #1 retire = 1'b0;
    rd(12'hB02);
    checks++; if (r_rd !== 32'd4) begin errors++; $display("FAIL minstret: got %0d expected 4", r_rd); end
    wr(12'h320, 32'h4);
    @(negedge clk); retire = 1'b1;
    repeat (3) @(posedge clk);
    #1 retire = 1'b0;
    rd(12'hB02);
    checks++; if (r_rd !== 32'd4) begin errors++; $display("FAIL minstret_inhibit: got %0d expected 4", r_rd); end
  endtask

  task automatic test_masks;
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320);
    checks++; if (r_rd !== 32'h7D) begin errors++; $display("FAIL inhibit_mask: got %h expected 7d", r_rd); end
    wr(12'h306, 32'hFFFF_FFFF);
    rd(12'h306);
    checks++; if (r_rd !== 32'h7F) begin errors++; $display("FAIL counteren_mask: got %h expected 7f", r_rd); end
  endtask

  task automatic test_unmapped;
    rd(12'hB01);
    checks++; if (r_h !== 1'b0 || r_f !== 1'b0 || r_rv !== 1'b0) begin errors++; $display("FAIL unmapped_b01: got hit=%b fault=%b rv=%b expected 0 0 0", r_h, r_f, r_rv); end
    rd(12'h7C0);
    checks++; if (r_h !== 1'b0 || r_rv !== 1'b0) begin errors++; $display("FAIL unmapped_7c0: got hit=%b rv=%b expected 0 0", r_h, r_rv); end
    rd(12'h327);
    checks++; if (r_h !== 1'b0) begin errors++; $display("FAIL unmapped_327: got %b expected 0", r_h); end
    rd(12'hB07);
    checks++; if (r_h !== 1'b0) begin errors++; $display("FAIL unmapped_b07: got %b expected 0", r_h); end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h323; csr_wdata = 32'h8000_0003;
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    csr_valid = 1'b0; csr_op = 2'b00;
    checks++; if (csr_rvalid !== 1'b0 || ovf_status !== 4'h0) begin errors++; $display("FAIL abort_outputs: got rv=%b status=%b expected 0 0000", csr_rvalid, ovf_status); end
    @(negedge clk); rst_n = 1'b1;
    rd(12'h323);
    checks++; if (r_rd !== 32'd0) begin errors++; $display("FAIL abort_no_write: got %h expected 0", r_rd); end
    rd(12'hB83);
    checks++; if (r_rd !== 32'd0) begin errors++; $display("FAIL abort_cnt_cleared: got %h expected 0", r_rd); end
  endtask

  initial begin
    test_reset;
    test_mcycle;
    test_event_count;
    test_overflow;
    test_user_access;
    test_readonly;
    test_write_vs_event;
    test_minstret;
    test_masks;
    test_unmapped;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
